// File: rtl/gnrl_bitstr_enc_if.sv
// ---------------------------------------------------------------------------
// gnrl_bitstr_enc_if
// Bundles the control, serial input and FIFO write signals of the run-length
// encoder so the encoder and its driver connect through one port.
//
//   start      begin a capture (honoured only while the encoder is idle)
//   stop       end a capture and flush the partial run
//   bitstr_in  serial level being encoded, sampled every clock
//   fifo_full  downstream FIFO cannot accept a word this cycle
//   wr_en      one-cycle FIFO write strobe
//   wr_data    encoded word {level, run count}
//   busy       encoder is capturing or flushing
//   d_end      one-cycle pulse once the final word of a capture is out
//   overflow   sticky flag: at least one word was dropped on a full FIFO
//
// The master modport drives the controls and watches the results.
// The slave modport is the encoder itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface gnrl_bitstr_enc_if #(
   parameter int BUS_WIDTH = 32
);
   logic                 start;
   logic                 stop;
   logic                 bitstr_in;
   logic                 fifo_full;
   logic                 wr_en;
   logic [BUS_WIDTH-1:0] wr_data;
   logic                 busy;
   logic                 d_end;
   logic                 overflow;

   modport master (
      output start, stop, bitstr_in, fifo_full,
      input  wr_en, wr_data, busy, d_end, overflow
   );

   modport slave (
      input  start, stop, bitstr_in, fifo_full,
      output wr_en, wr_data, busy, d_end, overflow
   );
endinterface

// File: rtl/gnrl_bitstr_enc.sv
// ---------------------------------------------------------------------------
// gnrl_bitstr_enc
// Run-length encoder for a serial bit stream. While capturing, it turns each
// run of equal levels into a word {level, count}, where count is the number
// of clocks the level was held (always >= 1). Runs longer than the count
// field can hold are split into full-scale words with no cycles lost.
//
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   gnrl_bitstr_enc_if slave port (controls, serial input, FIFO side)
//
// Words leave through a registered one-cycle write strobe. If the FIFO is
// full when a word is produced, that word is dropped, the sticky overflow
// flag is set, and encoding carries on without stalling.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module gnrl_bitstr_enc #(
   parameter int BUS_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   gnrl_bitstr_enc_if.slave  bus
);

   localparam int               CNT_W   = BUS_WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t               state_q,     state_d;
   logic                 first_q,     first_d;
   logic                 cur_level_q, cur_level_d;
   logic [CNT_W-1:0]     count_q,     count_d;
   logic                 wr_en_q,     wr_en_d;
   logic [BUS_WIDTH-1:0] wr_data_q,   wr_data_d;
   logic                 busy_q,      busy_d;
   logic                 d_end_q,     d_end_d;
   logic                 overflow_q,  overflow_d;

   logic                 emit;

   // Next-state and output computation for the whole encoder.
   // first_q marks the opening RUN cycle, which only seeds the run.
   // A STOP before that seed leaves count at zero, and a zero count is
   // never flushed because a word always stands for at least one cycle.
   // The flush word is registered on the STOP edge so that a run-end word
   // detected one cycle earlier and the flush word go out back to back.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      cur_level_d = cur_level_q;
      count_d     = count_q;
      wr_en_d     = 1'b0;
      wr_data_d   = wr_data_q;
      d_end_d     = 1'b0;
      overflow_d  = overflow_q;
      emit        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d    = RUN;
               first_d    = 1'b1;
               count_d    = '0;
               overflow_d = 1'b0;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = FLUSH;
               emit    = (count_q != '0);
            end else if (first_q) begin
               first_d     = 1'b0;
               cur_level_d = bus.bitstr_in;
               count_d     = CNT_ONE;
            end else if (bus.bitstr_in != cur_level_q) begin
               emit        = 1'b1;
               cur_level_d = bus.bitstr_in;
               count_d     = CNT_ONE;
            end else if (count_q == CNT_MAX) begin
               emit    = 1'b1;
               count_d = CNT_ONE;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         FLUSH: begin
            state_d = DONE;
            d_end_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The word always describes the run as it stood before this edge.
      if (emit) begin
         if (bus.fifo_full) begin
            overflow_d = 1'b1;
         end else begin
            wr_en_d   = 1'b1;
            wr_data_d = {cur_level_q, count_q};
         end
      end

      busy_d = (state_d == RUN) || (state_d == FLUSH);
   end

   // State and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         first_q     <= 1'b0;
         cur_level_q <= 1'b0;
         count_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         d_end_q     <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         cur_level_q <= cur_level_d;
         count_q     <= count_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         d_end_q     <= d_end_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;
   assign bus.d_end    = d_end_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_gnrl_bitstr_enc.sv
// ---------------------------------------------------------------------------
// tb_gnrl_bitstr_enc
// Drives a 32-bit and an 8-bit encoder from the same stimulus. Each capture
// feeds the bit list held in stim; the expected words come from splitting
// that list into runs of equal bits and cutting each run into pieces of at
// most the largest count the word can hold.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gnrl_bitstr_enc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic bitstr_in = 1'b0;
   logic fifo_full = 1'b0;

   always #5 clk = ~clk;

   gnrl_bitstr_enc_if #(.BUS_WIDTH(32)) bus32 ();
   gnrl_bitstr_enc_if #(.BUS_WIDTH(8))  bus8 ();

   assign bus32.start     = start;
   assign bus32.stop      = stop;
   assign bus32.bitstr_in = bitstr_in;
   assign bus32.fifo_full = fifo_full;
   assign bus8.start      = start;
   assign bus8.stop       = stop;
   assign bus8.bitstr_in  = bitstr_in;
   assign bus8.fifo_full  = fifo_full;

   gnrl_bitstr_enc #(.BUS_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   gnrl_bitstr_enc #(.BUS_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   int tests = 0;
   int fails = 0;

   bit          stim[$];
   logic [31:0] exp32[$];
   logic [7:0]  exp8[$];
   logic [31:0] got32[$];
   logic [7:0]  got8[$];
   int          got_cyc[$];
   int          dend32 = 0;
   int          dend8 = 0;
   int          cyc = 0;
   logic        busy_at_run;
   logic        ovf_at_run;
   int          idx;
   logic [31:0] gw, ew;

   // Free-running cycle stamp so back-to-back writes can be recognised.
   always @(posedge clk) cyc <= cyc + 1;

   // Collect every FIFO write and end pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus32.wr_en === 1'b1) begin
         got32.push_back(bus32.wr_data);
         got_cyc.push_back(cyc);
      end
      if (bus8.wr_en === 1'b1) got8.push_back(bus8.wr_data);
      if (bus32.d_end === 1'b1) dend32++;
      if (bus8.d_end === 1'b1) dend8++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected words: split stim into maximal runs, then cut each run into
   // pieces no longer than the largest count of the word width.
   function automatic void build_expected();
      int     i;
      int     w;
      longint mx;
      longint len;
      bit     lvl;
      exp32.delete();
      exp8.delete();
      for (int sel = 0; sel < 2; sel++) begin
         w  = (sel == 0) ? 32 : 8;
         mx = (longint'(1) << (w - 1)) - 1;
         i  = 0;
         while (i < stim.size()) begin
            lvl = stim[i];
            len = 0;
            while (i < stim.size() && stim[i] == lvl) begin
               len++;
               i++;
            end
            while (len > 0) begin
               if (sel == 0) exp32.push_back({lvl, 31'((len > mx) ? mx : len)});
               else          exp8.push_back({lvl, 7'((len > mx) ? mx : len)});
               len = (len > mx) ? len - mx : 0;
            end
         end
      end
   endfunction

   // Locates the first word where collected and expected queues differ.
   task automatic compare_words(input bit narrow, output int first,
                                output logic [31:0] g_word, output logic [31:0] e_word);
      int gn, en, n;
      logic [31:0] g, e;
      first  = -1;
      g_word = '0;
      e_word = '0;
      gn = narrow ? got8.size() : got32.size();
      en = narrow ? exp8.size() : exp32.size();
      n  = (gn > en) ? gn : en;
      for (int k = 0; k < n; k++) begin
         g = 'x;
         e = 'x;
         if (k < gn) g = narrow ? {24'h0, got8[k]} : got32[k];
         if (k < en) e = narrow ? {24'h0, exp8[k]} : exp32[k];
         if (g !== e) begin
            first  = k;
            g_word = g;
            e_word = e;
            return;
         end
      end
   endtask

   // One full capture of stim: START, the bits, STOP, then wait for D_END.
   task automatic run_capture(input bit rand_start);
      int base;
      got32.delete();
      got8.delete();
      got_cyc.delete();
      base  = dend32;
      start = 1'b1;
      stop  = 1'b0;
      step();
      start       = 1'b0;
      busy_at_run = bus32.busy;
      ovf_at_run  = bus32.overflow;
      foreach (stim[i]) begin
         bitstr_in = stim[i];
         if (rand_start) start = 1'($urandom_range(1));
         step();
      end
      start     = 1'b0;
      stop      = 1'b1;
      bitstr_in = 1'($urandom_range(1));
      step();
      stop = 1'b0;
      for (int k = 0; k < 10 && dend32 == base; k++) step();
      step();
      step();
      step();
      tests++;
      if (dend32 - base !== 1) begin
         fails++;
         $display("[TB] FAIL d_end_pulses: got %0d, expected 1", dend32 - base);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      tests++;
      if (bus32.wr_en !== 1'b0)   begin fails++; $display("[TB] FAIL reset_wr_en: got %b, expected 0", bus32.wr_en); end
      tests++;
      if (bus32.wr_data !== '0)   begin fails++; $display("[TB] FAIL reset_wr_data: got %h, expected 0", bus32.wr_data); end
      tests++;
      if (bus32.busy !== 1'b0)    begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus32.busy); end
      tests++;
      if (bus32.d_end !== 1'b0)   begin fails++; $display("[TB] FAIL reset_d_end: got %b, expected 0", bus32.d_end); end
      tests++;
      if (bus32.overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow: got %b, expected 0", bus32.overflow); end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      stim = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      build_expected();
      run_capture(1'b0);
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL basic_words: word %0d got %h, expected %h", idx, gw, ew); end
      tests++;
      if (got32.size() != 2 || got32[0] !== 32'h8000_0005 || got32[1] !== 32'h0000_0003) begin
         fails++;
         $display("[TB] FAIL basic_literal: got %0d words, expected 80000005 then 00000003", got32.size());
      end
      tests++;
      if (busy_at_run !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_run: got %b, expected 1", busy_at_run); end
      tests++;
      if (bus32.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_after: got %b, expected 0", bus32.busy); end
   endtask

   task automatic test_saturation();
      stim.delete();
      for (int i = 0; i < 130; i++) stim.push_back(1'b1);
      build_expected();
      run_capture(1'b0);
      compare_words(1'b1, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL sat_words8: word %0d got %h, expected %h", idx, gw, ew); end
      tests++;
      if (got8.size() != 2 || got8[0] !== 8'hFF || got8[1] !== 8'h83) begin
         fails++;
         $display("[TB] FAIL sat_literal8: got %0d words, expected FF then 83", got8.size());
      end
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL sat_words32: word %0d got %h, expected %h", idx, gw, ew); end
   endtask

   task automatic test_start_stop_together();
      int base;
      got32.delete();
      base  = dend32;
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 5; i++) step();
      tests++;
      if (got32.size() != 0 || dend32 != base || bus32.busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL start_stop_idle: got %0d writes %0d d_end busy %b, expected none", got32.size(), dend32 - base, bus32.busy);
      end
      stim.delete();
      run_capture(1'b0);
      tests++;
      if (got32.size() != 0) begin fails++; $display("[TB] FAIL empty_capture: got %0d writes, expected 0", got32.size()); end
   endtask

   task automatic test_overflow();
      fifo_full = 1'b1;
      stim = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      run_capture(1'b0);
      fifo_full = 1'b0;
      tests++;
      if (got32.size() != 0) begin fails++; $display("[TB] FAIL ovf_dropped: got %0d writes, expected 0", got32.size()); end
      step();
      step();
      tests++;
      if (bus32.overflow !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", bus32.overflow); end
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(1'($urandom_range(1)));
      build_expected();
      run_capture(1'b0);
      tests++;
      if (ovf_at_run !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear_on_start: got %b, expected 0", ovf_at_run); end
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL ovf_after_words: word %0d got %h, expected %h", idx, gw, ew); end
   endtask

   task automatic test_reset_mid_run();
      int base;
      got32.delete();
      base  = dend32;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bitstr_in = 1'b1;
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (bus32.wr_en !== 1'b0 || bus32.wr_data !== '0 || bus32.busy !== 1'b0 ||
          bus32.d_end !== 1'b0 || bus32.overflow !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rst_mid_run: got wr_en %b data %h busy %b d_end %b ovf %b, expected all 0",
                  bus32.wr_en, bus32.wr_data, bus32.busy, bus32.d_end, bus32.overflow);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (got32.size() != 0 || dend32 != base) begin
         fails++;
         $display("[TB] FAIL rst_discard: got %0d writes %0d d_end, expected 0 and 0", got32.size(), dend32 - base);
      end
      stim = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      build_expected();
      run_capture(1'b0);
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL rst_restart_words: word %0d got %h, expected %h", idx, gw, ew); end
   endtask

   task automatic test_back_to_back();
      int n;
      stim = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      build_expected();
      run_capture(1'b0);
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL b2b_words: word %0d got %h, expected %h", idx, gw, ew); end
      n = got_cyc.size();
      tests++;
      if (n < 2 || got_cyc[n-1] - got_cyc[n-2] != 1) begin
         fails++;
         $display("[TB] FAIL b2b_consecutive: got %0d writes, last gap not 1 cycle, expected gap 1", n);
      end
   endtask

   task automatic test_random();
      bit     rec[$];
      longint total;
      bit     zero_count;
      bit     lvl;
      lvl = 1'($urandom_range(1));
      stim.delete();
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(3) == 0) lvl = ~lvl;
         stim.push_back(lvl);
      end
      build_expected();
      run_capture(1'b1);
      compare_words(1'b0, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL rand_words32: word %0d got %h, expected %h", idx, gw, ew); end
      compare_words(1'b1, idx, gw, ew);
      tests++;
      if (idx >= 0) begin fails++; $display("[TB] FAIL rand_words8: word %0d got %h, expected %h", idx, gw, ew); end
      total      = 0;
      zero_count = 1'b0;
      foreach (got32[k]) begin
         if (got32[k][30:0] == 0) zero_count = 1'b1;
         total += got32[k][30:0];
         for (int j = 0; j < int'(got32[k][30:0]) && rec.size() < 2000; j++) rec.push_back(got32[k][31]);
      end
      tests++;
      if (total != stim.size() || zero_count) begin
         fails++;
         $display("[TB] FAIL rand_count_sum: got %0d (zero word %b), expected %0d", total, zero_count, stim.size());
      end
      tests++;
      if (rec != stim) begin
         fails++;
         $display("[TB] FAIL rand_reconstruct: got %0d bits back, expected identical %0d bits", rec.size(), stim.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_start_stop_together();
      test_overflow();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
